// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path: FSM states, parity codes and
// the layout of one receive-FIFO entry.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_PUSH   = 3'd6
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DATA_LEN_BASE = 5;

    localparam int ENTRY_W  = 10;
    localparam int FERR_BIT = 8;
    localparam int PERR_BIT = 9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is presented on dout whenever
// the FIFO is non-empty. A push into a full FIFO is taken only alongside a pop.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver with runtime frame format, 3-sample majority voting, break and
// idle-timeout detection, feeding a show-ahead FIFO of bytes plus error flags.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TO_BITS    = 32
) (
    input  logic                          mclk,
    input  logic                          reset,
    input  logic                          rxd,
    input  logic [15:0]                   baud_div,
    input  logic [1:0]                    data_len,
    input  logic [1:0]                    parity_sel,
    input  logic                          stop_sel,
    input  logic                          ren,
    output logic [7:0]                    rdata,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          rvalid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          ov_clr,
    output logic                          brk,
    output logic                          rx_timeout,
    output logic [2:0]                    debug_state
);
    localparam logic [7:0] TO_LAST = 8'(TO_BITS - 1);
    localparam logic [7:0] TO_MAX  = 8'(TO_BITS);

    state_t               state;
    logic [2:0]           sync;
    logic                 rxs, rxs_d, start_edge;
    logic [15:0]          cnt, mid, to_cyc;
    logic [7:0]           to_bits;
    logic                 samp_lo, samp_mid, voted, vote_now, bit_end;
    logic [2:0]           bit_idx, last_idx;
    logic [7:0]           shreg;
    logic                 par_bit, stop1_bit, stop_bad;
    logic                 par_en, par_exp, par_err;
    logic                 push_req, fifo_empty, fifo_full;
    logic [ENTRY_W-1:0]   fifo_din, fifo_dout;

    function automatic logic is_break(input logic [7:0] d, input logic pen,
                                      input logic pb, input logic s1);
        return (d == 8'h00) && (!pen || !pb) && !s1;
    endfunction

    assign rxs        = sync[2];
    assign start_edge = rxs_d && !rxs;
    assign mid        = {1'b0, baud_div[15:1]};
    assign voted      = maj3(samp_lo, samp_mid, rxs);
    assign vote_now   = (cnt == mid + 16'd1);
    assign bit_end    = (cnt >= baud_div);
    assign last_idx   = {1'b0, data_len} + 3'(DATA_LEN_BASE - 1);
    assign par_en     = (parity_sel == PAR_EVEN) || (parity_sel == PAR_ODD);
    assign par_exp    = (parity_sel == PAR_ODD) ? ~^shreg : ^shreg;
    assign par_err    = par_en && (par_bit != par_exp);
    assign push_req   = (state == ST_PUSH);
    assign fifo_din   = {par_err, stop_bad, shreg};
    assign debug_state = state;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            sync  <= 3'b111;
            rxs_d <= 1'b1;
        end else begin
            sync  <= {sync[1:0], rxd};
            rxs_d <= sync[2];
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            brk     <= 1'b0;
        end else begin
            brk <= 1'b0;
            if (state == ST_IDLE && start_edge) cnt <= '0;
            else if (bit_end)                   cnt <= '0;
            else                                cnt <= cnt + 16'd1;
            case (state)
                ST_IDLE:   if (start_edge) state <= ST_START;
                ST_START: begin
                    if (vote_now && voted) state <= ST_IDLE;
                    else if (bit_end) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == last_idx) state <= par_en ? ST_PARITY : ST_STOP1;
                        else                     bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_PARITY: if (bit_end) state <= ST_STOP1;
                // Stop bits finish at the vote, so a start bit right behind is not missed.
                ST_STOP1: begin
                    if (vote_now) begin
                        if (stop_sel) state <= ST_STOP2;
                        else begin
                            state <= ST_PUSH;
                            brk   <= is_break(shreg, par_en, par_bit, voted);
                        end
                    end
                end
                ST_STOP2: begin
                    if (vote_now) begin
                        state <= ST_PUSH;
                        brk   <= is_break(shreg, par_en, par_bit, stop1_bit);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (cnt == mid - 16'd1) samp_lo  <= rxs;
        if (cnt == mid)         samp_mid <= rxs;
        if (state == ST_IDLE && start_edge) begin
            shreg    <= '0;
            stop_bad <= 1'b0;
        end
        if (vote_now) begin
            case (state)
                ST_DATA:   shreg[bit_idx] <= voted;
                ST_PARITY: par_bit <= voted;
                ST_STOP1: begin
                    stop1_bit <= voted;
                    if (!voted) stop_bad <= 1'b1;
                end
                ST_STOP2:  if (!voted) stop_bad <= 1'b1;
                default: ;
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (mclk),
        .rst_n (reset),
        .push  (push_req),
        .din   (fifo_din),
        .pop   (ren),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign rvalid        = !fifo_empty;
    assign rdata         = fifo_empty ? 8'h00 : fifo_dout[7:0];
    assign rd_frame_err  = !fifo_empty && fifo_dout[FERR_BIT];
    assign rd_parity_err = !fifo_empty && fifo_dout[PERR_BIT];

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset)                             overrun <= 1'b0;
        else if (push_req && fifo_full && !ren) overrun <= 1'b1;
        else if (ov_clr)                        overrun <= 1'b0;
    end

    // Idle timer runs in whole bit periods measured from when the line went quiet with data waiting.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            to_cyc     <= '0;
            to_bits    <= '0;
            rx_timeout <= 1'b0;
        end else if (start_edge || (ren && rvalid) || fifo_empty) begin
            to_cyc     <= '0;
            to_bits    <= '0;
            rx_timeout <= 1'b0;
        end else if (state == ST_IDLE && rxs) begin
            if (to_cyc >= baud_div) begin
                to_cyc <= '0;
                if (to_bits != TO_MAX)  to_bits    <= to_bits + 8'd1;
                if (to_bits == TO_LAST) rx_timeout <= 1'b1;
            end else begin
                to_cyc <= to_cyc + 16'd1;
            end
        end
    end

endmodule
